// File: rtl/axi_lite_init_master_if.sv
// AXI4-Lite bus bundle for the init master: master drives requests, slave drives responses.
interface axi_lite_init_master_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_init_master.sv
// Writes INIT_VALUE+i to NUM_REGS consecutive registers over AXI4-Lite, reads them back,
// and reports mismatches and error responses. One transaction outstanding at a time.
module axi_lite_init_master #(
  parameter int unsigned                  NUM_REGS           = 4,
  parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR         = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] INIT_VALUE        = 32'h0000_0001
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [7:0]                    err_count,
  axi_lite_init_master_if.master        m_axi
);

  localparam int unsigned    IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      err_q, err_d;
  logic            pass_q, pass_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] cur_data;
  logic [7:0]                    err_inc;
  logic                          aw_fin, w_fin;

  // Both wrap naturally at their declared widths.
  assign cur_addr = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx_q) << 2);
  assign cur_data = INIT_VALUE + C_M_AXI_DATA_WIDTH'(idx_q);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    pass_d    = pass_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;

    m_axi.AWADDR  = '0;
    m_axi.AWPROT  = 3'b000;
    m_axi.AWVALID = 1'b0;
    m_axi.WDATA   = '0;
    m_axi.WSTRB   = '0;
    m_axi.WVALID  = 1'b0;
    m_axi.BREADY  = 1'b0;
    m_axi.ARADDR  = '0;
    m_axi.ARPROT  = 3'b000;
    m_axi.ARVALID = 1'b0;
    m_axi.RREADY  = 1'b0;

    busy = (state_q != StIdle);
    done = (state_q == StFinish);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d     = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrReq;
        end
      end
      StWrReq: begin
        m_axi.AWVALID = !aw_done_q;
        m_axi.WVALID  = !w_done_q;
        m_axi.AWADDR  = cur_addr;
        m_axi.WDATA   = cur_data;
        m_axi.WSTRB   = '1;
        // Each channel retires on its own handshake; move on once both have.
        aw_fin = aw_done_q | m_axi.AWREADY;
        w_fin  = w_done_q | m_axi.WREADY;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      StWrResp: begin
        m_axi.BREADY = 1'b1;
        if (m_axi.BVALID) begin
          if (m_axi.BRESP != 2'b00) err_d = err_inc;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StRdReq;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        m_axi.ARVALID = 1'b1;
        m_axi.ARADDR  = cur_addr;
        if (m_axi.ARREADY) state_d = StRdResp;
      end
      StRdResp: begin
        m_axi.RREADY = 1'b1;
        if (m_axi.RVALID) begin
          if ((m_axi.RDATA != cur_data) || (m_axi.RRESP != 2'b00)) err_d = err_inc;
          if (idx_q == LastIdx) begin
            pass_d  = (err_d == 8'd0);
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_axi_lite_init_master.sv
// Two DUT configurations against a configurable memory slave; a transaction-level model
// checks ordering, addresses, data, error counting, done/busy timing and reset behaviour.
module tb_axi_lite_init_master;

  localparam int unsigned N0    = 4;
  localparam int unsigned N1    = 130;
  localparam logic [31:0] Base0 = 32'h0000_0000;
  localparam logic [31:0] Base1 = 32'h0000_1000;
  localparam logic [31:0] Init0 = 32'h0000_0001;
  localparam logic [31:0] Init1 = 32'hFFFF_FFFE;
  localparam int          SeqTimeout = 2500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start = '0;
  logic [1:0]  busy, done, pass;
  logic [7:0]  err_count [2];
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [2:0]  awprot [2], arprot [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_init_master_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) bus ();
    axi_lite_init_master #(
      .NUM_REGS          ((g == 0) ? N0 : N1),
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .BASE_ADDR         ((g == 0) ? Base0 : Base1),
      .INIT_VALUE        ((g == 0) ? Init0 : Init1)
    ) dut (
      .ACLK     (clk),
      .ARESET   (rst),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .err_count(err_count[g]),
      .m_axi    (bus)
    );
    assign awaddr[g]   = bus.AWADDR;
    assign awprot[g]   = bus.AWPROT;
    assign awvalid[g]  = bus.AWVALID;
    assign wdata[g]    = bus.WDATA;
    assign wstrb[g]    = bus.WSTRB;
    assign wvalid[g]   = bus.WVALID;
    assign bready[g]   = bus.BREADY;
    assign araddr[g]   = bus.ARADDR;
    assign arprot[g]   = bus.ARPROT;
    assign arvalid[g]  = bus.ARVALID;
    assign rready[g]   = bus.RREADY;
    assign bus.AWREADY = awready[g];
    assign bus.WREADY  = wready[g];
    assign bus.BRESP   = bresp[g];
    assign bus.BVALID  = bvalid[g];
    assign bus.ARREADY = arready[g];
    assign bus.RDATA   = rdata[g];
    assign bus.RRESP   = rresp[g];
    assign bus.RVALID  = rvalid[g];
  end

  // ---------------- slave knobs and memory slave ----------------
  int          aw_dly [2], w_dly [2], b_dly [2];
  bit          corrupt_en [2], slverr_en [2], all_bad [2];
  logic [31:0] corrupt_addr [2], slverr_addr [2];
  logic [31:0] mem [2][256];
  int          aw_wait [2], w_wait [2], b_wait [2];
  bit          aw_got [2], w_got [2], b_pend [2];
  logic [31:0] got_addr [2], got_data [2];

  always_comb begin
    awready = '0;
    wready  = '0;
    arready = '0;
    bvalid  = '0;
    for (int d = 0; d < 2; d++) begin
      awready[d] = awvalid[d] && (aw_wait[d] >= aw_dly[d]);
      wready[d]  = wvalid[d] && (w_wait[d] >= w_dly[d]);
      arready[d] = arvalid[d];
      bvalid[d]  = b_pend[d] && (b_wait[d] >= b_dly[d]);
    end
  end

  always @(posedge clk or posedge rst) begin
    logic        a_now, w_now;
    logic [31:0] a_addr, w_dat;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        aw_wait[d] <= 0; w_wait[d] <= 0; b_wait[d] <= 0;
        aw_got[d]  <= 1'b0; w_got[d] <= 1'b0; b_pend[d] <= 1'b0;
        bresp[d]   <= 2'b00; rresp[d] <= 2'b00; rdata[d] <= '0;
      end
      rvalid <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        aw_wait[d] <= (awvalid[d] && !awready[d]) ? aw_wait[d] + 1 : 0;
        w_wait[d]  <= (wvalid[d] && !wready[d]) ? w_wait[d] + 1 : 0;
        a_now  = aw_got[d] || (awvalid[d] && awready[d]);
        w_now  = w_got[d] || (wvalid[d] && wready[d]);
        a_addr = aw_got[d] ? got_addr[d] : awaddr[d];
        w_dat  = w_got[d] ? got_data[d] : wdata[d];
        if (awvalid[d] && awready[d]) begin aw_got[d] <= 1'b1; got_addr[d] <= awaddr[d]; end
        if (wvalid[d] && wready[d]) begin w_got[d] <= 1'b1; got_data[d] <= wdata[d]; end
        if (a_now && w_now) begin
          mem[d][a_addr[9:2]] <= w_dat;
          aw_got[d] <= 1'b0;
          w_got[d]  <= 1'b0;
          b_pend[d] <= 1'b1;
          b_wait[d] <= 0;
          bresp[d]  <= (all_bad[d] || (slverr_en[d] && a_addr == slverr_addr[d])) ? 2'b10 : 2'b00;
        end else if (bvalid[d] && bready[d]) begin
          b_pend[d] <= 1'b0;
        end else if (b_pend[d] && !bvalid[d]) begin
          b_wait[d] <= b_wait[d] + 1;
        end
        if (arvalid[d] && arready[d]) begin
          rvalid[d] <= 1'b1;
          rdata[d]  <= (all_bad[d] || (corrupt_en[d] && araddr[d] == corrupt_addr[d])) ?
                       32'hDEAD_BEEF : mem[d][araddr[d][9:2]];
          rresp[d]  <= all_bad[d] ? 2'b10 : 2'b00;
        end else if (rvalid[d] && rready[d]) begin
          rvalid[d] <= 1'b0;
        end
      end
    end
  end

  // ---------------- transaction-level model and checker ----------------
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mb [2], pend_done [2], last_pass [2];
  int          aw_cnt [2], w_cnt [2], b_cnt [2], ar_cnt [2], r_cnt [2];
  int          raw_err [2], last_err [2], busy_cyc [2];
  bit          aw_hold [2], w_hold [2], ar_hold [2];
  logic [31:0] aw_hold_addr [2], w_hold_data [2], ar_hold_addr [2];
  logic [31:0] lit_addr [2][4], lit_wdata [2][4];
  logic [7:0]  lit_err [2];
  bit          lit_pass [2];

  function automatic int num_regs(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic logic [31:0] exp_addr(input int d, input int i);
    return ((d == 0) ? Base0 : Base1) + 32'(i * 4);
  endfunction

  function automatic logic [31:0] exp_data(input int d, input int i);
    return ((d == 0) ? Init0 : Init1) + 32'(i);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        check("rst_status", d, {busy[d], done[d], pass[d], err_count[d]}, '0);
        check("rst_valid_ready", d, {awvalid[d], wvalid[d], bready[d], arvalid[d], rready[d]}, '0);
        check("rst_addr_data", d, {awaddr[d], wdata[d]}, '0);
        check("rst_araddr", d, araddr[d], '0);
        mb[d] = 1'b0; pend_done[d] = 1'b0; last_pass[d] = 1'b0; last_err[d] = 0;
        aw_cnt[d] = 0; w_cnt[d] = 0; b_cnt[d] = 0; ar_cnt[d] = 0; r_cnt[d] = 0;
        raw_err[d] = 0; busy_cyc[d] = 0;
        aw_hold[d] = 1'b0; w_hold[d] = 1'b0; ar_hold[d] = 1'b0;
      end else begin
        bit was_busy;
        was_busy = mb[d];
        check("busy", d, busy[d], mb[d]);
        check("done", d, done[d], pend_done[d]);
        if (!mb[d]) begin
          check("idle_err_hold", d, err_count[d], last_err[d]);
          check("idle_pass_hold", d, pass[d], last_pass[d]);
          check("idle_no_valid", d, {awvalid[d], wvalid[d], arvalid[d]}, '0);
        end else begin
          check("err_running", d, err_count[d], sat8(raw_err[d]));
          busy_cyc[d]++;
          if (busy_cyc[d] == SeqTimeout) begin
            n_chk++;
            n_fail++;
            $display("FAIL seq_timeout dut%0d: busy %0d cycles, required done", d, busy_cyc[d]);
          end
        end
        if (aw_hold[d]) check("aw_stable", d, {awvalid[d], awaddr[d]}, {1'b1, aw_hold_addr[d]});
        if (w_hold[d]) check("w_stable", d, {wvalid[d], wdata[d]}, {1'b1, w_hold_data[d]});
        if (ar_hold[d]) check("ar_stable", d, {arvalid[d], araddr[d]}, {1'b1, ar_hold_addr[d]});

        if (awvalid[d] && awready[d]) begin
          check("aw_order", d, aw_cnt[d], b_cnt[d]);
          check("awaddr", d, awaddr[d], exp_addr(d, aw_cnt[d]));
          check("awprot", d, awprot[d], 3'b000);
          if (aw_cnt[d] < 4) check("awaddr_lit", d, awaddr[d], lit_addr[d][aw_cnt[d]]);
          aw_cnt[d]++;
        end
        if (wvalid[d] && wready[d]) begin
          check("w_order", d, w_cnt[d], b_cnt[d]);
          check("wdata", d, wdata[d], exp_data(d, w_cnt[d]));
          check("wstrb", d, wstrb[d], 4'hF);
          if (w_cnt[d] < 4) check("wdata_lit", d, wdata[d], lit_wdata[d][w_cnt[d]]);
          w_cnt[d]++;
        end
        if (bvalid[d] && bready[d]) begin
          check("b_after_aw_w", d, {aw_cnt[d], w_cnt[d]}, {b_cnt[d] + 1, b_cnt[d] + 1});
          if (bresp[d] != 2'b00) raw_err[d]++;
          b_cnt[d]++;
        end
        if (arvalid[d]) begin
          check("ar_after_writes", d, b_cnt[d], num_regs(d));
          check("ar_one_outstanding", d, ar_cnt[d], r_cnt[d]);
        end
        if (arvalid[d] && arready[d]) begin
          check("araddr", d, araddr[d], exp_addr(d, ar_cnt[d]));
          check("arprot", d, arprot[d], 3'b000);
          ar_cnt[d]++;
        end
        pend_done[d] = 1'b0;
        if (rvalid[d] && rready[d]) begin
          if ((rdata[d] != exp_data(d, r_cnt[d])) || (rresp[d] != 2'b00)) raw_err[d]++;
          r_cnt[d]++;
          pend_done[d] = (r_cnt[d] == num_regs(d));
        end
        if (done[d]) begin
          check("done_txn_count", d, {b_cnt[d], r_cnt[d]}, {num_regs(d), num_regs(d)});
          check("done_err", d, err_count[d], sat8(raw_err[d]));
          check("done_pass", d, pass[d], raw_err[d] == 0);
          check("done_err_lit", d, err_count[d], lit_err[d]);
          check("done_pass_lit", d, pass[d], lit_pass[d]);
          last_err[d]  = sat8(raw_err[d]);
          last_pass[d] = (raw_err[d] == 0);
          mb[d] = 1'b0;
        end
        if (start[d] && !was_busy) begin
          mb[d] = 1'b1;
          aw_cnt[d] = 0; w_cnt[d] = 0; b_cnt[d] = 0; ar_cnt[d] = 0; r_cnt[d] = 0;
          raw_err[d] = 0; busy_cyc[d] = 0;
        end
        aw_hold[d] = awvalid[d] && !awready[d]; aw_hold_addr[d] = awaddr[d];
        w_hold[d]  = wvalid[d] && !wready[d];   w_hold_data[d]  = wdata[d];
        ar_hold[d] = arvalid[d] && !arready[d]; ar_hold_addr[d] = araddr[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int d);
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < SeqTimeout + 10; i++) begin
      @(negedge clk);
      if (done[d]) break;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input int d);
    pulse_start(d);
    wait_done(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      aw_dly[d] = 0; w_dly[d] = 0; b_dly[d] = 0;
      corrupt_en[d] = 1'b0; slverr_en[d] = 1'b0; all_bad[d] = 1'b0;
      corrupt_addr[d] = '0; slverr_addr[d] = '0;
      lit_err[d] = 8'd0; lit_pass[d] = 1'b1;
    end
    lit_addr[0][0] = 32'h0;         lit_addr[0][1] = 32'h4;
    lit_addr[0][2] = 32'h8;         lit_addr[0][3] = 32'hC;
    lit_wdata[0][0] = 32'h1;        lit_wdata[0][1] = 32'h2;
    lit_wdata[0][2] = 32'h3;        lit_wdata[0][3] = 32'h4;
    lit_addr[1][0] = 32'h1000;      lit_addr[1][1] = 32'h1004;
    lit_addr[1][2] = 32'h1008;      lit_addr[1][3] = 32'h100C;
    lit_wdata[1][0] = 32'hFFFF_FFFE; lit_wdata[1][1] = 32'hFFFF_FFFF;
    lit_wdata[1][2] = 32'h0000_0000; lit_wdata[1][3] = 32'h0000_0001;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain sequence, always-ready slave.
    run(0);
    // Skewed write channels, both orders.
    aw_dly[0] = 3; run(0); aw_dly[0] = 0;
    w_dly[0] = 3;  run(0); w_dly[0] = 0;
    // Corrupted read of 0x8, then also SLVERR on write of 0x4.
    corrupt_en[0] = 1'b1; corrupt_addr[0] = 32'h8;
    lit_err[0] = 8'd1; lit_pass[0] = 1'b0; run(0);
    slverr_en[0] = 1'b1; slverr_addr[0] = 32'h4;
    lit_err[0] = 8'd2; run(0);
    corrupt_en[0] = 1'b0; slverr_en[0] = 1'b0;
    lit_err[0] = 8'd0; lit_pass[0] = 1'b1;

    // Wrapping data on the second instance, then every response bad -> saturation.
    run(1);
    all_bad[1] = 1'b1; lit_err[1] = 8'hFF; lit_pass[1] = 1'b0; run(1);
    all_bad[1] = 1'b0; lit_err[1] = 8'd0; lit_pass[1] = 1'b1;

    // Reset while waiting for the write response of index 2.
    b_dly[0] = 5;
    pulse_start(0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bready[0] && b_cnt[0] == 2) break;
    end
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    b_dly[0] = 0;
    repeat (4) @(posedge clk);
    run(0);

    // Extra start while busy must be ignored.
    b_dly[0] = 2;
    pulse_start(0);
    repeat (4) @(posedge clk);
    pulse_start(0);
    wait_done(0);
    repeat (10) @(posedge clk);
    b_dly[0] = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
